// File: rtl/lacpu_mem_pkg.sv
// Shared memory-side types for the lite SoC: response source tags and the
// default RAM geometry.
package lacpu_mem_pkg;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_INST = 2'd1,
      SRC_DATA = 2'd2
   } src_e;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 32;

   // Tag of the requester that owns the RAM this cycle. Grants are one-hot.
   function automatic src_e grant_src(input logic inst_gnt, input logic data_gnt);
      src_e src;
      src = SRC_NONE;
      if (inst_gnt) begin
         src = SRC_INST;
      end else if (data_gnt) begin
         src = SRC_DATA;
      end
      return src;
   endfunction

endpackage

// File: rtl/prio_starve_sel.sv
// Data-priority grant selector. Fetch wins a conflict once it has been
// denied STARVE_LIM consecutive cycles.
module prio_starve_sel #(
   parameter int STARVE_LIM = 4
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic                             inst_req,
   input  logic                             data_req,
   output logic                             inst_gnt,
   output logic                             data_gnt,
   output logic [$clog2(STARVE_LIM+1)-1:0]  starve_cnt
);

   localparam int CNT_W = $clog2(STARVE_LIM + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);

   logic [CNT_W-1:0] starve_cnt_q;
   logic [CNT_W-1:0] starve_cnt_d;
   logic             starved;

   always_comb begin
      inst_gnt     = 1'b0;
      data_gnt     = 1'b0;
      starve_cnt_d = '0;
      starved      = (starve_cnt_q == CNT_MAX);

      // No grants at all while reset is held.
      if (resetn) begin
         if (inst_req && data_req) begin
            inst_gnt = starved;
            data_gnt = ~starved;
         end else begin
            inst_gnt = inst_req;
            data_gnt = data_req;
         end
      end

      if (inst_req && !inst_gnt) begin
         starve_cnt_d = starved ? starve_cnt_q : (starve_cnt_q + CNT_W'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign starve_cnt = starve_cnt_q;

endmodule

// File: rtl/uni_ram_arbiter.sv
// Shares one single-port, one-cycle-latency RAM between CPU fetch and data
// ports, steering each response back to the requester that issued it.
module uni_ram_arbiter
   import lacpu_mem_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_LIM = 4
) (
   input  logic                             clk,
   input  logic                             resetn,

   input  logic                             inst_req,
   input  logic [DATA_W/8-1:0]              inst_wen,
   input  logic [31:0]                      inst_addr,
   input  logic [DATA_W-1:0]                inst_wdata,
   output logic                             inst_gnt,
   output logic                             inst_rvalid,
   output logic [DATA_W-1:0]                inst_rdata,

   input  logic                             data_req,
   input  logic [DATA_W/8-1:0]              data_wen,
   input  logic [31:0]                      data_addr,
   input  logic [DATA_W-1:0]                data_wdata,
   output logic                             data_gnt,
   output logic                             data_rvalid,
   output logic [DATA_W-1:0]                data_rdata,

   output logic                             ram_en,
   output logic [DATA_W/8-1:0]              ram_wen,
   output logic [ADDR_W-1:0]                ram_addr,
   output logic [DATA_W-1:0]                ram_wdata,
   input  logic [DATA_W-1:0]                ram_rdata,

   output logic [$clog2(STARVE_LIM+1)-1:0]  dbg_starve_cnt,
   output logic [1:0]                       dbg_resp_src
);

   src_e resp_src_q;
   src_e resp_src_d;

   prio_starve_sel #(
      .STARVE_LIM (STARVE_LIM)
   ) u_sel (
      .clk        (clk),
      .resetn     (resetn),
      .inst_req   (inst_req),
      .data_req   (data_req),
      .inst_gnt   (inst_gnt),
      .data_gnt   (data_gnt),
      .starve_cnt (dbg_starve_cnt)
   );

   // Request-side mux: the granted requester drives the RAM, otherwise all zero.
   always_comb begin
      ram_en     = inst_gnt | data_gnt;
      ram_wen    = '0;
      ram_addr   = '0;
      ram_wdata  = '0;
      resp_src_d = grant_src(inst_gnt, data_gnt);
      if (inst_gnt) begin
         ram_wen   = inst_wen;
         ram_addr  = inst_addr[ADDR_W+1:2];
         ram_wdata = inst_wdata;
      end else if (data_gnt) begin
         ram_wen   = data_wen;
         ram_addr  = data_addr[ADDR_W+1:2];
         ram_wdata = data_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         resp_src_q <= SRC_NONE;
      end else begin
         resp_src_q <= resp_src_d;
      end
   end

   // Response mux is gated by resetn so a grant issued just before reset
   // never produces an rvalid.
   always_comb begin
      inst_rvalid = 1'b0;
      inst_rdata  = '0;
      data_rvalid = 1'b0;
      data_rdata  = '0;
      if (resetn) begin
         case (resp_src_q)
            SRC_INST: begin
               inst_rvalid = 1'b1;
               inst_rdata  = ram_rdata;
            end
            SRC_DATA: begin
               data_rvalid = 1'b1;
               data_rdata  = ram_rdata;
            end
            default: ;
         endcase
      end
   end

   assign dbg_resp_src = resp_src_q;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0],
                               data_addr[31:ADDR_W+2], data_addr[1:0]};

endmodule

// File: tb/tb_uni_ram_arbiter.sv
// Randomized and directed bench for uni_ram_arbiter against a transaction-level
// model of the arbitration and response rules.
module tb_uni_ram_arbiter;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 32;
   localparam int STARVE_LIM = 4;
   localparam int CNT_W      = $clog2(STARVE_LIM + 1);

   logic              clk;
   logic              resetn;
   logic              inst_req, data_req;
   logic [3:0]        inst_wen, data_wen;
   logic [31:0]       inst_addr, data_addr;
   logic [31:0]       inst_wdata, data_wdata;
   logic              inst_gnt, data_gnt;
   logic              inst_rvalid, data_rvalid;
   logic [31:0]       inst_rdata, data_rdata;
   logic              ram_en;
   logic [3:0]        ram_wen;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;
   logic [CNT_W-1:0]  dbg_starve_cnt;
   logic [1:0]        dbg_resp_src;

   uni_ram_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STARVE_LIM (STARVE_LIM)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .inst_req       (inst_req),
      .inst_wen       (inst_wen),
      .inst_addr      (inst_addr),
      .inst_wdata     (inst_wdata),
      .inst_gnt       (inst_gnt),
      .inst_rvalid    (inst_rvalid),
      .inst_rdata     (inst_rdata),
      .data_req       (data_req),
      .data_wen       (data_wen),
      .data_addr      (data_addr),
      .data_wdata     (data_wdata),
      .data_gnt       (data_gnt),
      .data_rvalid    (data_rvalid),
      .data_rdata     (data_rdata),
      .ram_en         (ram_en),
      .ram_wen        (ram_wen),
      .ram_addr       (ram_addr),
      .ram_wdata      (ram_wdata),
      .ram_rdata      (ram_rdata),
      .dbg_starve_cnt (dbg_starve_cnt),
      .dbg_resp_src   (dbg_resp_src)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- RAM behind the DUT (with a bench preload port) ----------------
   logic [31:0] ram_mem [0:(1<<ADDR_W)-1];
   logic        pre_we;
   logic [5:0]  pre_addr;
   logic [31:0] pre_data;

   always @(posedge clk) begin
      if (pre_we) begin
         ram_mem[{10'd0, pre_addr}] <= pre_data;
      end else if (ram_en) begin
         ram_rdata <= ram_mem[ram_addr];
         for (int b = 0; b < 4; b++) begin
            if (ram_wen[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         end
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [0:63];
   logic [32:0] inst_exp_q[$];   // {is_write, expected read data}
   logic [32:0] data_exp_q[$];
   int          denied;          // consecutive cycles fetch waited
   logic        m_ig, m_dg;
   int          n_cmp, n_mis;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] preload_val(input int k);
      logic [31:0] v;
      v = 32'(k) * 32'h9E37_79B1;
      if (k == 16'h10) v = 32'hDEAD_BEEF;
      if (k == 16'h20) v = 32'h0000_0000;
      if (k == 16'h30) v = 32'h1234_5678;
      if (k == 16'h31) v = 32'hCAFE_F00D;
      return v;
   endfunction

   task automatic check_resp(input string nm, input logic rv, input logic [31:0] rd,
                             inout logic [32:0] q[$]);
      logic [32:0] e;
      if (!resetn) begin
         chk({nm, "_rvalid_rst"}, rv, 0);
         chk({nm, "_rdata_rst"}, rd, 0);
      end else if (q.size() > 0) begin
         e = q.pop_front();
         chk({nm, "_rvalid"}, rv, 1);
         if (!e[32]) chk({nm, "_rdata"}, rd, e[31:0]);
      end else begin
         chk({nm, "_rvalid_idle"}, rv, 0);
         chk({nm, "_rdata_idle"}, rd, 0);
      end
   endtask

   task automatic model_check();
      logic [3:0]  e_wen;
      logic [15:0] e_addr;
      logic [31:0] e_wdata;
      logic [5:0]  w;
      if (!resetn) begin
         m_ig = 0; m_dg = 0;
      end else if (inst_req && data_req) begin
         m_ig = (denied == STARVE_LIM);
         m_dg = !m_ig;
      end else begin
         m_ig = inst_req; m_dg = data_req;
      end
      e_wen = 0; e_addr = 0; e_wdata = 0;
      if (m_ig) begin
         e_wen = inst_wen; e_addr = inst_addr[17:2]; e_wdata = inst_wdata;
      end else if (m_dg) begin
         e_wen = data_wen; e_addr = data_addr[17:2]; e_wdata = data_wdata;
      end
      chk("inst_gnt", inst_gnt, m_ig);
      chk("data_gnt", data_gnt, m_dg);
      chk("ram_en", ram_en, m_ig | m_dg);
      chk("ram_wen", ram_wen, e_wen);
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_wdata", ram_wdata, e_wdata);
      chk("starve_cnt", dbg_starve_cnt, denied);
      if (resetn) begin
         chk("resp_src", dbg_resp_src,
             (inst_exp_q.size() > 0) ? 2'd1 : (data_exp_q.size() > 0) ? 2'd2 : 2'd0);
      end
      check_resp("inst", inst_rvalid, inst_rdata, inst_exp_q);
      check_resp("data", data_rvalid, data_rdata, data_exp_q);

      if (!resetn) begin
         inst_exp_q.delete();
         data_exp_q.delete();
         denied = 0;
      end else begin
         w = e_addr[5:0];
         if (m_ig | m_dg) begin
            if (m_ig) inst_exp_q.push_back({|e_wen, ref_mem[w]});
            else      data_exp_q.push_back({|e_wen, ref_mem[w]});
            for (int b = 0; b < 4; b++) begin
               if (e_wen[b]) ref_mem[w][8*b +: 8] = e_wdata[8*b +: 8];
            end
         end
         denied = (inst_req && !m_ig) ? ((denied < STARVE_LIM) ? denied + 1 : denied) : 0;
      end
   endtask

   task automatic step_begin();
      #1;
      model_check();
   endtask

   task automatic step_end();
      @(negedge clk);
   endtask

   task automatic idle_steps(input int n);
      inst_req = 0; data_req = 0;
      for (int i = 0; i < n; i++) begin
         step_begin();
         step_end();
      end
   endtask

   task automatic set_inst(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
      inst_req = 1; inst_addr = a; inst_wen = we; inst_wdata = wd;
   endtask

   task automatic set_data(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
      data_req = 1; data_addr = a; data_wen = we; data_wdata = wd;
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      n_mis++;
      $display("FAIL watchdog: got timeout expected finish");
      summary();
      $finish;
   end

   // ---------------- stimulus ----------------
   logic i_pend, d_pend;

   initial begin
      n_cmp = 0; n_mis = 0; denied = 0;
      resetn = 0; pre_we = 0; pre_addr = 0; pre_data = 0;
      inst_req = 0; inst_wen = 0; inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
      i_pend = 0; d_pend = 0;
      @(negedge clk);
      for (int k = 0; k < 64; k++) begin
         pre_we = 1; pre_addr = 6'(k); pre_data = preload_val(k);
         ref_mem[k] = preload_val(k);
         @(negedge clk);
      end
      pre_we = 0;

      // Reset held with both requesting
      set_inst(32'h0, 4'h0, 32'h0);
      set_data(32'h4, 4'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step_begin();
         chk("rst_inst_gnt", inst_gnt, 0);
         chk("rst_data_gnt", data_gnt, 0);
         chk("rst_ram_en", ram_en, 0);
         chk("rst_rvalid", {inst_rvalid, data_rvalid}, 0);
         step_end();
      end
      resetn = 1;
      step_begin();
      chk("rel_data_gnt", data_gnt, 1);
      chk("rel_inst_gnt", inst_gnt, 0);
      step_end();
      data_req = 0;
      step_begin(); step_end();
      idle_steps(2);

      // Isolated fetch read
      set_inst(32'h40, 4'h0, 32'h0);
      step_begin();
      chk("fetch_gnt", inst_gnt, 1);
      chk("fetch_ram_addr", ram_addr, 16'h10);
      step_end();
      inst_req = 0;
      step_begin();
      chk("fetch_rvalid", inst_rvalid, 1);
      chk("fetch_rdata", inst_rdata, 32'hDEAD_BEEF);
      chk("fetch_data_rvalid", data_rvalid, 0);
      step_end();

      // Data byte write, then read back
      set_data(32'h80, 4'b0010, 32'h0000_AB00);
      step_begin();
      chk("wr_gnt", data_gnt, 1);
      chk("wr_ram_wen", ram_wen, 4'b0010);
      step_end();
      set_data(32'h80, 4'h0, 32'h0);
      step_begin();
      chk("wr_ack", data_rvalid, 1);
      step_end();
      data_req = 0;
      step_begin();
      chk("rd_rvalid", data_rvalid, 1);
      chk("rd_rdata", data_rdata, 32'h0000_AB00);
      step_end();
      idle_steps(1);

      // Starvation pattern: data x4, inst x1, repeating
      set_inst(32'h40, 4'h0, 32'h0);
      set_data(32'h80, 4'h0, 32'h0);
      for (int i = 0; i < 10; i++) begin
         step_begin();
         chk("starve_inst_gnt", inst_gnt, (i % 5) == 4);
         chk("starve_data_gnt", data_gnt, (i % 5) != 4);
         step_end();
      end
      idle_steps(2);

      // Alternating sources, no conflict
      set_inst(32'hC0, 4'h0, 32'h0);
      step_begin(); step_end();
      inst_req = 0;
      set_data(32'hC4, 4'h0, 32'h0);
      step_begin();
      chk("alt_inst_rdata", inst_rdata, 32'h1234_5678);
      chk("alt_data_rvalid0", data_rvalid, 0);
      step_end();
      data_req = 0;
      set_inst(32'hC4, 4'h0, 32'h0);
      step_begin();
      chk("alt_data_rdata", data_rdata, 32'hCAFE_F00D);
      chk("alt_inst_rvalid0", inst_rvalid, 0);
      chk("alt_inst_rdata0", inst_rdata, 0);
      step_end();
      inst_req = 0;
      step_begin();
      chk("alt_inst_rdata2", inst_rdata, 32'hCAFE_F00D);
      step_end();

      // Reset right after a data read grant
      set_data(32'h80, 4'h0, 32'h0);
      step_begin();
      chk("mid_gnt", data_gnt, 1);
      step_end();
      data_req = 0; resetn = 0;
      step_begin();
      chk("mid_rvalid_rst", data_rvalid, 0);
      step_end();
      resetn = 1;
      step_begin();
      chk("mid_rvalid_after", data_rvalid, 0);
      chk("mid_starve_cnt", dbg_starve_cnt, 0);
      step_end();
      set_inst(32'h40, 4'h0, 32'h0);
      set_data(32'h80, 4'h0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         step_begin();
         chk("mid_starve_inst_gnt", inst_gnt, i == 4);
         step_end();
      end
      idle_steps(2);

      // Randomized traffic with occasional reset
      for (int c = 0; c < 2000; c++) begin
         resetn = ($urandom_range(0, 99) != 0);
         if (!i_pend && $urandom_range(0, 99) < 55) begin
            i_pend = 1;
            inst_wen = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            inst_addr = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 63)) << 2) | ($urandom & 32'h3);
            inst_wdata = $urandom;
         end
         if (!d_pend && $urandom_range(0, 99) < 70) begin
            d_pend = 1;
            data_wen = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            data_addr = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 63)) << 2) | ($urandom & 32'h3);
            data_wdata = $urandom;
         end
         inst_req = i_pend;
         data_req = d_pend;
         step_begin();
         if (m_ig || !resetn) i_pend = 0;
         if (m_dg || !resetn) d_pend = 0;
         step_end();
      end
      resetn = 1;
      idle_steps(3);

      summary();
      $finish;
   end

endmodule

// File: doc/uni_ram_arbiter.md
# uni_ram_arbiter

Shares one single-port, synchronous-read block RAM between the CPU instruction-fetch and data-access requesters in the lite SoC top. The block sits between `mycpu_top`'s instruction and data SRAM-style ports and one unified RAM with one-cycle read latency. It grants at most one access per cycle, with data priority and a starvation limit for fetch. It routes each read response back to the requester that issued it.

## Interface
- `ADDR_W`, default 16: RAM word-address width. The RAM address is `addr[ADDR_W+1:2]`.
- `DATA_W`, default 32: data width. Byte-enable width is `DATA_W/8`.
- `STARVE_LIM`, default 4: consecutive denied fetch cycles after which fetch wins a conflict. Legal range is ≥1.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `inst_req` in 1: fetch request. It stays high, with `inst_wen`, `inst_addr` and `inst_wdata` stable, until `inst_gnt`.
- `inst_wen` in `DATA_W/8`: byte write enables. Zero means read.
- `inst_addr` in 32: byte address.
- `inst_wdata` in `DATA_W`: write data.
- `inst_gnt` out 1: request accepted this cycle (combinational).
- `inst_rvalid` out 1: completion, one cycle after grant.
- `inst_rdata` out `DATA_W`: read data, valid when `inst_rvalid`.
- `data_req`, `data_wen`, `data_addr`, `data_wdata`, `data_gnt`, `data_rvalid`, `data_rdata`: same as the `inst_*` set, for the data requester.
- `ram_en` out 1: RAM enable.
- `ram_wen` out `DATA_W/8`: RAM byte write enables.
- `ram_addr` out `ADDR_W`: RAM word address.
- `ram_wdata` out `DATA_W`: RAM write data.
- `ram_rdata` in `DATA_W`: RAM read data, one cycle after `ram_en`.

## Operation
- **Grant rule, each cycle:**
  - Only one requester high: that requester is granted.
  - Both high: data is granted, unless `starve_cnt == STARVE_LIM`; then inst is granted.
  - Neither high: no grant, and `ram_en` is 0.
- **RAM drive:** `ram_en = inst_gnt | data_gnt`. `ram_wen`, `ram_addr` and `ram_wdata` are muxed from the granted requester. With no grant, they are 0.
- **Starvation counter `starve_cnt`** (width `$clog2(STARVE_LIM+1)`):
  - Increments when `inst_req & ~inst_gnt`, saturating at `STARVE_LIM`.
  - Clears to 0 on `inst_gnt` or `~inst_req`.
- **Response source register `resp_src`** (`SRC_NONE`, `SRC_INST`, `SRC_DATA`): loaded every cycle with the granted source, or `SRC_NONE`.
- **Response outputs in the cycle after a grant:**
  - `<src>_rvalid` = 1 for reads and writes.
  - `<src>_rdata = ram_rdata`.
  - The other requester's `rvalid` = 0 and its `rdata` = 0.
- Writes complete with `rvalid`. `rdata` on a write ack is whatever the RAM returns and is don't-care to the requester.
- Back-to-back grants to the same requester are legal every cycle (full throughput).
- A requester may raise a new `req` in the same cycle its previous `rvalid` is high.
- Address bits `[31:ADDR_W+2]` and `[1:0]` are ignored. No range checking.

## Timing
- **Reset** (`resetn` low at a clock edge):
  - `resp_src` ← `SRC_NONE` and `starve_cnt` ← 0.
  - In the next cycle, `inst_rvalid`, `data_rvalid`, `inst_rdata` and `data_rdata` are 0.
  - While `resetn` is low, `inst_gnt`, `data_gnt`, `ram_en`, `ram_wen`, `ram_addr` and `ram_wdata` are 0.
- **Reset mid-operation:** a grant issued in the cycle before reset is asserted has its response dropped; no `rvalid` follows.
- **Latency:** `req` to `gnt` is 0 cycles if uncontended. `gnt` to `rvalid` is exactly 1 cycle.
- **Worst-case fetch wait under continuous data requests:** `STARVE_LIM` cycles. Fetch is granted in the cycle where the count equals `STARVE_LIM`.
- **Counter in the conflict cycle:** when fetch wins a conflict, `starve_cnt` clears at that edge. Data is denied that cycle and keeps its request.
- **`rdata` path:** combinational from `ram_rdata` through a mux selected by `resp_src`. No extra register.

## Structure
- **Shared package `lacpu_mem_pkg`:**
  - `src_e` enum (`SRC_NONE=2'd0`, `SRC_INST=2'd1`, `SRC_DATA=2'd2`).
  - Defaults for `ADDR_W` and `DATA_W`.
- **Sub-module `prio_starve_sel`:** the grant logic plus the starvation counter. It takes `inst_req` and `data_req` and produces the two grants. The top holds the RAM mux and the response register.

## Test plan
1. **Reset:** hold `resetn`=0 for 3 cycles with both `req`=1. Expect all grants, `rvalid`s and `ram_en` at 0. On release, data is granted in the first cycle.
2. **Isolated fetch read:** preload word 0x10 = 0xDEADBEEF; `inst_req` with `addr=0x40`, `wen=0`. Expect `inst_gnt` the same cycle and `ram_addr=0x10`. Next cycle, expect `inst_rvalid=1` and `inst_rdata=0xDEADBEEF`, with `data_rvalid=0`.
3. **Data byte write then read:**
   - Data write: `addr=0x80`, `wen=4'b0010`, `wdata=0x0000AB00`, onto a word holding 0.
   - Then a data read of 0x80, which returns 0x0000AB00.
   - Each access has `data_rvalid` one cycle after grant.
4. **Starvation, `STARVE_LIM`=4:** both requesting continuously. Expect data granted in cycles 0–3, inst granted in cycle 4, then data again. The pattern repeats every 5 cycles.
5. **Alternating sources:** grants alternate inst, data, inst with no conflict. Each `rvalid` goes only to its issuer and returns its own address's data.
6. **Mid-operation reset:** a data read is granted at cycle N and `resetn`=0 is sampled at edge N+1. Expect `data_rvalid` to stay 0 and `starve_cnt` to be 0.
